sub_bytes_pipe: RTL
===================

// Module: sub_bytes_pipe
// PURPOSE
//  Parametrised, pipelined AES SubBytes/InvSubBytes engine; applies the S-box (or inverse S-box) to NUM_LANES bytes per beat.
//  Shared by the round datapath (NUM_LANES=16, full state) and key expansion (NUM_LANES=4, SubWord).
//  Elastic valid/ready pipeline: 1 beat/cycle throughput, full backpressure, synchronous flush.
// PARAMETERS
//  NUM_LANES    4   bytes substituted per beat (1..16)
//  PIPE_STAGES  2   1 = lookup then output reg; 2 = input reg, lookup, output reg
//  INV_EN       1   1 = inverse table built and in_inv honoured; 0 = forward only, in_inv ignored
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              synchronous reset, active low
//  clr        in   1              synchronous flush: drops every in-flight beat
//  in_valid   in   1              input beat valid
//  in_ready   out  1              engine accepts a beat this cycle
//  in_data    in   8*NUM_LANES    bytes; lane k = in_data[8k+7:8k]
//  in_inv     in   1              1 = inverse S-box for this beat
//  out_valid  out  1              result valid
//  out_ready  in   1              downstream accepts the result
//  out_data   out  8*NUM_LANES    substituted bytes, same lane order
//  out_inv    out  1              in_inv of the beat, carried with it
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all stage valids=0; all stage data regs, out_data and out_inv=0. in_ready=0 while rst_n=0.
//  - Each stage holds valid/data/inv and loads when it is empty or its content advances in the same cycle.
//    Output stage advances when out_ready=1.
//  - in_ready = !s1_valid | s1_advance. Combinational from out_ready; no skid buffer.
//  - Transfer happens on (valid & ready) at clk edge.
//  - Latency, no backpressure: beat accepted at edge N gives out_valid=1 in the cycle after edge N+PIPE_STAGES-1.
//    PIPE_STAGES=1 means the next cycle.
//  - Throughput: one beat per cycle while out_ready=1. No bubbles inserted.
//  - Backpressure: with out_ready=0, stages fill and in_ready drops once all PIPE_STAGES hold data.
//    out_data/out_inv hold stable while out_valid=1 and out_ready=0.
//  - Beats never reorder, duplicate or drop, except on clr/rst_n.
//  - Lookup per lane: INV_EN & inv ? INV_SBOX[byte] : SBOX[byte]. Mode is selected per beat.
//    Mixed-mode beats can be back-to-back.
//  - clr=1: all stage valids cleared at the edge; in_ready=0 that cycle, so a simultaneous in_valid beat is dropped.
//    Data regs are not cleared.
//  - clr and rst_n both asserted: reset wins.
//  - out_valid=1 with out_ready=1 and a new beat in the prior stage: output reloads in the same edge (full rate).
// STRUCTURE
//  - aes_pkg: AES_BYTE_W=8; functions aes_sbox(byte) and aes_inv_sbox(byte) as the two 256-entry FIPS-197 tables.
//  - Sub-module sbox_lut #(INV_EN): one combinational byte lookup (in byte, inv -> out byte).
//    Instantiated NUM_LANES times via generate.
//  - Pipeline control in this module: generate on PIPE_STAGES selects the input reg; output reg is always present.
// TESTING
//  1 Forward, NUM_LANES=4, in_data=32'h53_00_01_FF, in_inv=0
//    -> out_data=32'hED_63_7C_16, after PIPE_STAGES cycles.
//  2 Inverse: in_data=32'hED_63_7C_16, in_inv=1 -> 32'h53_00_01_FF.
//    With INV_EN=0, same input -> 32'h55_FB_10_47 (forward).
//  3 Streaming: 64 random beats, alternating in_inv, out_ready=1
//    -> one result per cycle, in order, all match the model; in_ready never low.
//  4 Backpressure: out_ready=0 for 10 cycles while driving beats
//    -> exactly PIPE_STAGES beats accepted; out_data stable; all delivered in order after release.
//  5 Flush: clr=1 with pipeline full and in_valid=1
//    -> next cycle out_valid=0, no beat from before the flush ever appears; a beat sent after clr returns normally.
//  6 Reset mid-stream: rst_n=0 for one edge with pipeline full
//    -> out_valid=0, out_data=0, in_ready=0 during reset; normal latency after rst_n=1.

Source files
------------

// File: rtl/aes_pkg.sv
// AES byte-substitution constants: the FIPS-197 forward and inverse S-box tables
// plus lookup helpers shared by the round datapath and key expansion.
package aes_pkg;

    localparam int AES_BYTE_W = 8;

    // Entry 0 sits in the most significant byte, so row 0 is listed first.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [AES_BYTE_W-1:0] aes_sbox(input logic [AES_BYTE_W-1:0] b);
        return SBOX_TBL[(255 - int'(b)) * AES_BYTE_W +: AES_BYTE_W];
    endfunction

    function automatic logic [AES_BYTE_W-1:0] aes_inv_sbox(input logic [AES_BYTE_W-1:0] b);
        return INV_SBOX_TBL[(255 - int'(b)) * AES_BYTE_W +: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/sbox_lut.sv
// Single-byte combinational S-box lookup; the inverse table only exists when INV_EN is set.
module sbox_lut
    import aes_pkg::*;
#(
    parameter int INV_EN = 1
) (
    input  logic [AES_BYTE_W-1:0] byte_i,
    input  logic                  inv_i,
    output logic [AES_BYTE_W-1:0] byte_o
);

    generate
        if (INV_EN != 0) begin : g_both
            assign byte_o = inv_i ? aes_inv_sbox(byte_i) : aes_sbox(byte_i);
        end else begin : g_fwd
            // Mode bit has no effect in a forward-only build.
            logic unused_inv;
            assign unused_inv = inv_i;
            assign byte_o     = aes_sbox(byte_i);
        end
    endgenerate

endmodule

// File: rtl/sub_bytes_pipe.sv
// Elastic valid/ready SubBytes/InvSubBytes pipeline: optional input register,
// per-lane S-box lookup, then an always-present output register.
//
// Handshake: a beat moves across any interface on a clock edge where valid and
// ready are both high; a producer holds valid and its payload until that edge,
// and ready may depend combinationally on out_ready (no skid buffer).
module sub_bytes_pipe
    import aes_pkg::*;
#(
    parameter int NUM_LANES   = 4,
    parameter int PIPE_STAGES = 2,
    parameter int INV_EN      = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [AES_BYTE_W*NUM_LANES-1:0] in_data,
    input  logic                          in_inv,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [AES_BYTE_W*NUM_LANES-1:0] out_data,
    output logic                          out_inv
);

    localparam int W = AES_BYTE_W * NUM_LANES;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_inv_q, out_inv_d;

    logic         out_load;
    logic         lk_valid;
    logic [W-1:0] lk_data;
    logic         lk_inv;
    logic [W-1:0] lut_data;

    // Output register may take a new beat when empty or when its beat leaves this edge.
    assign out_load = !out_valid_q || out_ready;

    generate
        if (PIPE_STAGES >= 2) begin : g_in_reg
            logic         s1_valid_q, s1_valid_d;
            logic [W-1:0] s1_data_q, s1_data_d;
            logic         s1_inv_q, s1_inv_d;

            assign in_ready = rst_n && !clr && (!s1_valid_q || out_load);

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_data_d  = s1_data_q;
                s1_inv_d   = s1_inv_q;
                if (clr) begin
                    s1_valid_d = 1'b0;
                end else if (!s1_valid_q || out_load) begin
                    s1_valid_d = in_valid;
                    if (in_valid) begin
                        s1_data_d = in_data;
                        s1_inv_d  = in_inv;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_inv_q   <= 1'b0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_data_q  <= s1_data_d;
                    s1_inv_q   <= s1_inv_d;
                end
            end

            assign lk_valid = s1_valid_q;
            assign lk_data  = s1_data_q;
            assign lk_inv   = s1_inv_q;
        end else begin : g_no_in_reg
            assign in_ready = rst_n && !clr && out_load;
            assign lk_valid = in_valid && in_ready;
            assign lk_data  = in_data;
            assign lk_inv   = in_inv;
        end
    endgenerate

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        sbox_lut #(
            .INV_EN(INV_EN)
        ) u_lut (
            .byte_i(lk_data[AES_BYTE_W*k +: AES_BYTE_W]),
            .inv_i (lk_inv),
            .byte_o(lut_data[AES_BYTE_W*k +: AES_BYTE_W])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_inv_d   = out_inv_q;
        if (clr) begin
            out_valid_d = 1'b0;
        end else if (out_load) begin
            out_valid_d = lk_valid;
            if (lk_valid) begin
                out_data_d = lut_data;
                out_inv_d  = lk_inv;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_inv_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_inv_q   <= out_inv_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_inv   = out_inv_q;

endmodule
